axi4_lite_reg_slave: RTL and testbench
======================================

Name: axi4_lite_reg_slave

Overview:
- AXI4-Lite responder that exposes a bank of NUM_REGS software-visible control registers to fabric logic.
- It is the register-file endpoint paired with the existing AXI4-Lite master.
- AW and W are accepted independently and in either order; full WSTRB byte-enable support.
- Decode errors return SLVERR; one outstanding transaction per direction.
- Registers are driven out as a flat bus, with a per-register write strobe.

Parameters:
- ADDRESS_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data and register width; must be 32 or 64.
- NUM_REGS, 16, number of registers; 1..256.
- BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- S_AXI_AWADDR  in  ADDRESS_WIDTH  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDRESS_WIDTH  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-cycle strobe per register on an OKAY write.

Behaviour:
- Reset (ARESET high at rising edge):
  - All registers, all READY/VALID outputs, RDATA, RRESP, BRESP and wr_pulse go to 0.
  - Any in-flight transaction is discarded; no response is issued for it.
  - READYs assert in the first cycle after ARESET deasserts.
- READY outputs depend only on registered state; there is no combinational input-to-output path.
- Decode:
  - idx = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low address bits are ignored.
  - Out of range when addr < BASE_ADDR or idx >= NUM_REGS.
- Write FSM states: W_COLLECT, W_RESP.
  - W_COLLECT:
    - AWREADY = !aw_held; WREADY = !w_held.
    - A handshake (VALID and READY at an edge) latches address or data+strobe and sets the matching held flag.
    - AW and W may complete in the same edge or in any order, with any gap.
    - On the edge where the second of the two completes: commit the write, set BVALID and BRESP, go to W_RESP.
  - Commit:
    - In range: each byte k with WSTRB[k]=1 is updated; other bytes are kept. BRESP=OKAY (00). wr_pulse[idx]=1 for exactly the next cycle, even if WSTRB=0.
    - Out of range: no register change, no pulse, BRESP=SLVERR (10).
  - W_RESP:
    - AWREADY = WREADY = 0. BVALID and BRESP are held stable until BREADY.
    - On the BVALID&BREADY edge: clear BVALID and both held flags, go to W_COLLECT.
  - Latency: B appears 1 cycle after the later of AW/W. Maximum throughput is 1 write per 2 cycles.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, register RDATA and RRESP, set RVALID, go to R_DATA.
    - In range: RDATA = reg[idx], RRESP=OKAY.
    - Out of range: RDATA=0, RRESP=SLVERR.
  - R_DATA: ARREADY=0. RVALID, RDATA and RRESP are held stable until RREADY. On the RVALID&RREADY edge: clear RVALID, go to R_IDLE.
- Read and write channels are fully independent.
  - An AR handshake on the same edge as a commit to the same register returns the pre-write value.
- reg_q reflects the new value in the cycle after commit, i.e. the same cycle as BVALID first high.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State encodings for the write and read FSMs.
  - A function computing the address LSB count from DATA_WIDTH.
- One sub-module, axi4_lite_reg_bank: storage, strobe merge, index decode, range check and wr_pulse generation.
- Both FSMs stay in the top block.

Test Plan:
- Basic write/read:
  - AW=0x8 and W=0xDEADBEEF, WSTRB=0xF in the same cycle, BREADY=1 -> BVALID one cycle later with BRESP=00, reg2=0xDEADBEEF, wr_pulse[2] one cycle.
  - Then AR=0x8 -> RDATA=0xDEADBEEF, RRESP=00.
- Partial strobe: reg2=0xDEADBEEF, write 0x11223344 with WSTRB=4'b0101 -> reg2=0xDE22BE44.
- Out-of-order channels:
  - W=0xA5A5A5A5 issued 3 cycles before AW=0x4 -> WREADY low after capture; BVALID 1 cycle after the AW handshake; reg1=0xA5A5A5A5.
- Decode error:
  - Write to 0x40 (NUM_REGS=16) -> BRESP=10, no wr_pulse, all registers unchanged.
  - Read from 0x40 -> RDATA=0, RRESP=10.
- Backpressure:
  - BREADY low 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout.
  - RREADY low 4 cycles -> RVALID and RDATA stable, ARREADY=0.
- Reset mid-response:
  - Assert ARESET while BVALID=1 -> next cycle BVALID=0 and all registers=0.
  - READYs reassert in the first cycle after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM encodings and address helpers
// for the register slave and its register bank.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } wrState_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rdState_t;

    // Number of byte-offset bits dropped when turning a byte address into a register index.
    function automatic int addrLsbCount(input int dataWidth);
        return (dataWidth == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the register slave.
interface axi4_lite_reg_slave_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// Register storage with byte-strobe merge, address decode/range check and
// a one-cycle per-register write pulse.
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter int                     NUM_REGS      = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_wrEn,
    input  logic [ADDRESS_WIDTH-1:0]       i_wrAddr,
    input  logic [DATA_WIDTH-1:0]          i_wrData,
    input  logic [DATA_WIDTH/8-1:0]        i_wrStrb,
    input  logic [ADDRESS_WIDTH-1:0]       i_rdAddr,
    output logic                           o_wrInRange,
    output logic                           o_rdInRange,
    output logic [DATA_WIDTH-1:0]          o_rdData,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regQ,
    output logic [NUM_REGS-1:0]            o_wrPulse
);

    localparam int ADDR_LSB = addrLsbCount(DATA_WIDTH);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] NUM_REGS_A = ADDRESS_WIDTH'(NUM_REGS);

    logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]      r_wrPulse;
    logic [ADDRESS_WIDTH-1:0] w_wrIdxFull;
    logic [ADDRESS_WIDTH-1:0] w_rdIdxFull;
    logic [IDX_W-1:0]         w_wrIdx;
    logic [IDX_W-1:0]         w_rdIdx;

    // The full-width index is kept for the range test so huge offsets never alias.
    assign w_wrIdxFull = (i_wrAddr - BASE_ADDR) >> ADDR_LSB;
    assign w_rdIdxFull = (i_rdAddr - BASE_ADDR) >> ADDR_LSB;
    assign o_wrInRange = (i_wrAddr >= BASE_ADDR) && (w_wrIdxFull < NUM_REGS_A);
    assign o_rdInRange = (i_rdAddr >= BASE_ADDR) && (w_rdIdxFull < NUM_REGS_A);
    assign w_wrIdx     = w_wrIdxFull[IDX_W-1:0];
    assign w_rdIdx     = w_rdIdxFull[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wrPulse <= '0;
        end else begin
            r_wrPulse <= '0;
            if (i_wrEn && o_wrInRange) begin
                r_wrPulse[w_wrIdx] <= 1'b1;
                for (int k = 0; k < STRB_W; k++) begin
                    if (i_wrStrb[k]) begin
                        r_regs[w_wrIdx][8*k +: 8] <= i_wrData[8*k +: 8];
                    end
                end
            end
        end
    end

    assign o_rdData  = o_rdInRange ? r_regs[w_rdIdx] : '0;
    assign o_wrPulse = r_wrPulse;

    always_comb begin
        o_regQ = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_regQ[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register-file slave: independent write (AW/W collect + B) and read
// (AR + R) state machines in front of a register bank.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter int                     NUM_REGS      = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axi4_lite_reg_slave_if.slave           s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic                     r_readyEn;
    wrState_t                 r_wState, w_wStateNext;
    logic                     r_awHeld, w_awHeldNext;
    logic                     r_wHeld, w_wHeldNext;
    logic [ADDRESS_WIDTH-1:0] r_awAddr;
    logic [DATA_WIDTH-1:0]    r_wData;
    logic [STRB_W-1:0]        r_wStrb;
    logic                     r_bvalid, w_bvalidNext;
    logic [1:0]               r_bresp, w_brespNext;
    rdState_t                 r_rState, w_rStateNext;
    logic                     r_rvalid, w_rvalidNext;
    logic [DATA_WIDTH-1:0]    r_rdata, w_rdataNext;
    logic [1:0]               r_rresp, w_rrespNext;

    logic                     w_awReady, w_wReady, w_arReady;
    logic                     w_awHs, w_wHs, w_arHs;
    logic                     w_commit;
    logic [ADDRESS_WIDTH-1:0] w_commitAddr;
    logic [DATA_WIDTH-1:0]    w_commitData;
    logic [STRB_W-1:0]        w_commitStrb;
    logic                     w_wrInRange, w_rdInRange;
    logic [DATA_WIDTH-1:0]    w_bankRdData;

    // READYs come only from flops; r_readyEn keeps them low until the cycle after reset.
    assign w_awReady = r_readyEn && (r_wState == W_COLLECT) && !r_awHeld;
    assign w_wReady  = r_readyEn && (r_wState == W_COLLECT) && !r_wHeld;
    assign w_arReady = r_readyEn && (r_rState == R_IDLE);
    assign w_awHs    = s_axi.S_AXI_AWVALID && w_awReady;
    assign w_wHs     = s_axi.S_AXI_WVALID && w_wReady;
    assign w_arHs    = s_axi.S_AXI_ARVALID && w_arReady;

    assign w_commitAddr = r_awHeld ? r_awAddr : s_axi.S_AXI_AWADDR;
    assign w_commitData = r_wHeld  ? r_wData  : s_axi.S_AXI_WDATA;
    assign w_commitStrb = r_wHeld  ? r_wStrb  : s_axi.S_AXI_WSTRB;

    axi4_lite_reg_bank #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_REGS      (NUM_REGS),
        .BASE_ADDR     (BASE_ADDR)
    ) u_bank (
        .clk         (ACLK),
        .rst         (ARESET),
        .i_wrEn      (w_commit),
        .i_wrAddr    (w_commitAddr),
        .i_wrData    (w_commitData),
        .i_wrStrb    (w_commitStrb),
        .i_rdAddr    (s_axi.S_AXI_ARADDR),
        .o_wrInRange (w_wrInRange),
        .o_rdInRange (w_rdInRange),
        .o_rdData    (w_bankRdData),
        .o_regQ      (reg_q),
        .o_wrPulse   (wr_pulse)
    );

    always_comb begin
        w_wStateNext = r_wState;
        w_awHeldNext = r_awHeld;
        w_wHeldNext  = r_wHeld;
        w_bvalidNext = r_bvalid;
        w_brespNext  = r_bresp;
        w_commit     = 1'b0;
        case (r_wState)
            W_COLLECT: begin
                if (w_awHs) w_awHeldNext = 1'b1;
                if (w_wHs)  w_wHeldNext  = 1'b1;
                if ((r_awHeld || w_awHs) && (r_wHeld || w_wHs)) begin
                    w_commit     = 1'b1;
                    w_bvalidNext = 1'b1;
                    w_brespNext  = w_wrInRange ? RESP_OKAY : RESP_SLVERR;
                    w_wStateNext = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    w_bvalidNext = 1'b0;
                    w_awHeldNext = 1'b0;
                    w_wHeldNext  = 1'b0;
                    w_wStateNext = W_COLLECT;
                end
            end
            default: w_wStateNext = W_COLLECT;
        endcase
    end

    always_comb begin
        w_rStateNext = r_rState;
        w_rvalidNext = r_rvalid;
        w_rdataNext  = r_rdata;
        w_rrespNext  = r_rresp;
        case (r_rState)
            R_IDLE: begin
                if (w_arHs) begin
                    w_rvalidNext = 1'b1;
                    w_rdataNext  = w_bankRdData;
                    w_rrespNext  = w_rdInRange ? RESP_OKAY : RESP_SLVERR;
                    w_rStateNext = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    w_rvalidNext = 1'b0;
                    w_rStateNext = R_IDLE;
                end
            end
            default: w_rStateNext = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_readyEn <= 1'b0;
            r_wState  <= W_COLLECT;
            r_awHeld  <= 1'b0;
            r_wHeld   <= 1'b0;
            r_awAddr  <= '0;
            r_wData   <= '0;
            r_wStrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rState  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_readyEn <= 1'b1;
            r_wState  <= w_wStateNext;
            r_awHeld  <= w_awHeldNext;
            r_wHeld   <= w_wHeldNext;
            if (w_awHs) r_awAddr <= s_axi.S_AXI_AWADDR;
            if (w_wHs) begin
                r_wData <= s_axi.S_AXI_WDATA;
                r_wStrb <= s_axi.S_AXI_WSTRB;
            end
            r_bvalid  <= w_bvalidNext;
            r_bresp   <= w_brespNext;
            r_rState  <= w_rStateNext;
            r_rvalid  <= w_rvalidNext;
            r_rdata   <= w_rdataNext;
            r_rresp   <= w_rrespNext;
        end
    end

    assign s_axi.S_AXI_AWREADY = w_awReady;
    assign s_axi.S_AXI_WREADY  = w_wReady;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = w_arReady;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Self-checking bench for axi4_lite_reg_slave: table of write/read-back vectors
// with queued expectations, plus hand sequences for ordering, backpressure and reset.
module tb_axi4_lite_reg_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic ACLK = 1'b0;
    logic ARESET;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    wr_pulse;

    always #5 ACLK = ~ACLK;

    axi4_lite_reg_slave_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi4_lite_reg_slave #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_REGS      (NR),
        .BASE_ADDR     (32'h0)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .s_axi    (axi),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    typedef struct {
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [3:0]    strb;
        logic [1:0]    bresp;
        logic [NR-1:0] pulse;
        logic [31:0]   rdata;
        logic [1:0]    rresp;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rExp_t;

    int          nChecks = 0;
    int          nFail   = 0;
    logic [31:0] mdl [NR];
    logic [1:0]  bq [$];
    rExp_t       rq [$];
    vec_t        vecs [8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkRegs(input string name);
        logic [NR*DW-1:0] expFlat;
        for (int i = 0; i < NR; i++) expFlat[i*DW +: DW] = mdl[i];
        nChecks++;
        if (reg_q !== expFlat) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, reg_q, expFlat);
        end
    endtask

    function automatic logic isReady(input int which);
        case (which)
            0: return axi.S_AXI_AWREADY && axi.S_AXI_WREADY;
            1: return axi.S_AXI_ARREADY;
            2: return axi.S_AXI_WREADY;
            3: return axi.S_AXI_AWREADY;
            default: return axi.S_AXI_AWREADY && axi.S_AXI_WREADY && axi.S_AXI_ARREADY;
        endcase
    endfunction

    // Waits on negedges until the selected READYs are high; the next posedge is the handshake.
    task automatic waitReady(input string name, input int which);
        int cyc = 0;
        while (!isReady(which) && cyc < 50) begin
            @(negedge ACLK);
            cyc++;
        end
        if (cyc >= 50) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s_timeout: got ready=0 expected ready=1 within 50 cycles", name);
        end
    endtask

    task automatic collectB(input string name);
        checkOutput({name, "_bvalid"}, 64'(axi.S_AXI_BVALID), 64'd1);
        if (bq.size() > 0) begin
            checkOutput({name, "_bresp"}, 64'(axi.S_AXI_BRESP), 64'(bq.pop_front()));
        end else begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s_scoreboard: got empty B queue expected an entry", name);
        end
    endtask

    task automatic collectR(input string name);
        rExp_t e;
        checkOutput({name, "_rvalid"}, 64'(axi.S_AXI_RVALID), 64'd1);
        if (rq.size() > 0) begin
            e = rq.pop_front();
            checkOutput({name, "_rdata"}, 64'(axi.S_AXI_RDATA), 64'(e.data));
            checkOutput({name, "_rresp"}, 64'(axi.S_AXI_RRESP), 64'(e.resp));
        end else begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s_scoreboard: got empty R queue expected an entry", name);
        end
    endtask

    task automatic mergeModel(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr >> 2);
        if (addr < 32'h40) begin
            for (int k = 0; k < 4; k++) if (strb[k]) mdl[idx][8*k +: 8] = data[8*k +: 8];
        end
    endtask

    // Issues AW and W together with BREADY high and checks the response cycle.
    task automatic applyStimulus(input vec_t v);
        @(negedge ACLK);
        axi.S_AXI_AWADDR  = v.addr;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = v.data;
        axi.S_AXI_WSTRB   = v.strb;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_BREADY  = 1'b1;
        bq.push_back(v.bresp);
        waitReady("write", 0);
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        mergeModel(v.addr, v.data, v.strb);
        collectB("write");
        checkOutput("write_pulse", 64'(wr_pulse), 64'(v.pulse));
        checkRegs("write_reg_q");
        @(negedge ACLK);
        checkOutput("write_bvalid_clear", 64'(axi.S_AXI_BVALID), 64'd0);
        checkOutput("write_pulse_clear", 64'(wr_pulse), 64'd0);
    endtask

    task automatic readTxn(input logic [31:0] addr, input logic [31:0] expData, input logic [1:0] expResp);
        @(negedge ACLK);
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_RREADY  = 1'b1;
        rq.push_back('{data: expData, resp: expResp});
        waitReady("read", 1);
        @(negedge ACLK);
        axi.S_AXI_ARVALID = 1'b0;
        collectR("read");
    endtask

    initial begin
        vecs[0] = '{32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0004, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{32'h08, 32'h11223344, 4'h5, 2'b00, 16'h0004, 32'hDE22BE44, 2'b00};
        vecs[2] = '{32'h00, 32'h12345678, 4'hF, 2'b00, 16'h0001, 32'h12345678, 2'b00};
        vecs[3] = '{32'h3C, 32'hCAFEF00D, 4'h3, 2'b00, 16'h8000, 32'h0000F00D, 2'b00};
        vecs[4] = '{32'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 16'h0000, 32'h00000000, 2'b10};
        vecs[5] = '{32'h17, 32'hABCD0123, 4'h8, 2'b00, 16'h0020, 32'hAB000000, 2'b00};
        vecs[6] = '{32'h0C, 32'h55555555, 4'h0, 2'b00, 16'h0008, 32'h00000000, 2'b00};
        vecs[7] = '{32'hFFFFFFFC, 32'h5A5A5A5A, 4'hF, 2'b10, 16'h0000, 32'h00000000, 2'b10};
        for (int i = 0; i < NR; i++) mdl[i] = '0;

        ARESET            = 1'b1;
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;

        repeat (3) @(negedge ACLK);
        checkOutput("rst_awready", 64'(axi.S_AXI_AWREADY), 64'd0);
        checkOutput("rst_wready", 64'(axi.S_AXI_WREADY), 64'd0);
        checkOutput("rst_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
        checkOutput("rst_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
        checkOutput("rst_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
        checkOutput("rst_pulse", 64'(wr_pulse), 64'd0);
        checkRegs("rst_reg_q");
        ARESET = 1'b0;
        @(negedge ACLK);
        checkOutput("post_rst_ready", 64'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}), 64'b111);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            readTxn(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
        end

        // W three cycles ahead of AW.
        @(negedge ACLK);
        axi.S_AXI_WDATA  = 32'hA5A5A5A5;
        axi.S_AXI_WSTRB  = 4'hF;
        axi.S_AXI_WVALID = 1'b1;
        axi.S_AXI_BREADY = 1'b1;
        bq.push_back(2'b00);
        waitReady("ooo_w", 2);
        @(negedge ACLK);
        axi.S_AXI_WVALID = 1'b0;
        checkOutput("ooo_wready_low", 64'(axi.S_AXI_WREADY), 64'd0);
        checkOutput("ooo_awready_high", 64'(axi.S_AXI_AWREADY), 64'd1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("ooo_no_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
            @(negedge ACLK);
        end
        axi.S_AXI_AWADDR  = 32'h4;
        axi.S_AXI_AWVALID = 1'b1;
        waitReady("ooo_aw", 3);
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
        mergeModel(32'h4, 32'hA5A5A5A5, 4'hF);
        collectB("ooo");
        checkOutput("ooo_pulse", 64'(wr_pulse), 64'h0002);
        checkRegs("ooo_reg_q");
        @(negedge ACLK);
        checkOutput("ooo_bvalid_clear", 64'(axi.S_AXI_BVALID), 64'd0);

        // B channel held off for five cycles.
        axi.S_AXI_AWADDR  = 32'h10;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = 32'h0BADF00D;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_BREADY  = 1'b0;
        bq.push_back(2'b00);
        waitReady("bp_write", 0);
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        mergeModel(32'h10, 32'h0BADF00D, 4'hF);
        collectB("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checkOutput("bp_bvalid_hold", 64'(axi.S_AXI_BVALID), 64'd1);
            checkOutput("bp_bresp_hold", 64'(axi.S_AXI_BRESP), 64'd0);
            checkOutput("bp_ready_low", 64'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY}), 64'd0);
        end
        axi.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        checkOutput("bp_bvalid_clear", 64'(axi.S_AXI_BVALID), 64'd0);
        checkOutput("bp_ready_back", 64'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY}), 64'b11);

        // R channel held off for four cycles.
        axi.S_AXI_ARADDR  = 32'h10;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_RREADY  = 1'b0;
        rq.push_back('{data: 32'h0BADF00D, resp: 2'b00});
        waitReady("rbp", 1);
        @(negedge ACLK);
        axi.S_AXI_ARVALID = 1'b0;
        collectR("rbp");
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checkOutput("rbp_rvalid_hold", 64'(axi.S_AXI_RVALID), 64'd1);
            checkOutput("rbp_rdata_hold", 64'(axi.S_AXI_RDATA), 64'h0BADF00D);
            checkOutput("rbp_arready_low", 64'(axi.S_AXI_ARREADY), 64'd0);
        end
        axi.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        checkOutput("rbp_rvalid_clear", 64'(axi.S_AXI_RVALID), 64'd0);
        checkOutput("rbp_arready_back", 64'(axi.S_AXI_ARREADY), 64'd1);

        // AR on the same edge as a commit to the same register sees the old value.
        axi.S_AXI_AWADDR  = 32'h18;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = 32'h77777777;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_ARADDR  = 32'h18;
        axi.S_AXI_ARVALID = 1'b1;
        bq.push_back(2'b00);
        rq.push_back('{data: 32'h0, resp: 2'b00});
        waitReady("same_edge", 4);
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_ARVALID = 1'b0;
        mergeModel(32'h18, 32'h77777777, 4'hF);
        collectB("same_edge");
        collectR("same_edge");
        checkRegs("same_edge_reg_q");
        readTxn(32'h18, 32'h77777777, 2'b00);

        // Reset while a write response is pending.
        @(negedge ACLK);
        axi.S_AXI_AWADDR  = 32'h1C;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = 32'h13579BDF;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_BREADY  = 1'b0;
        bq.push_back(2'b00);
        waitReady("mid_rst", 0);
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        collectB("mid_rst");
        ARESET = 1'b1;
        @(negedge ACLK);
        bq.delete();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        checkOutput("mid_rst_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
        checkOutput("mid_rst_awready", 64'(axi.S_AXI_AWREADY), 64'd0);
        checkRegs("mid_rst_reg_q");
        ARESET = 1'b0;
        axi.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        checkOutput("mid_rst_ready_back", 64'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}), 64'b111);
        checkOutput("mid_rst_no_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
        readTxn(32'h08, 32'h0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
